// File: rtl/msk_share_skid_pipe.sv
// Two-entry skid pipeline stage for d-share Boolean sharings, with full throughput and FIFO order.
// Define MSK_PIPE_REFRESH_EN to re-randomise every sharing as it is captured.
`ifdef MSK_PIPE_REFRESH_EN
module msk_share_refresh_lane #(
    parameter int d = 2
) (
    input  logic [d-1:0] sh_i,
    input  logic [d-2:0] r_i,
    output logic [d-1:0] sh_o
);
    logic [d-1:0] mask;

    // Share 0 absorbs the XOR of all masks so the unmasked value is unchanged.
    always_comb begin
        mask = '0;
        for (int k = 1; k < d; k++) begin
            mask[k] = r_i[k-1];
            mask[0] = mask[0] ^ r_i[k-1];
        end
    end

    assign sh_o = sh_i ^ mask;
endmodule
`endif

module msk_share_skid_pipe #(
    parameter int d     = 2,
    parameter int count = 1,
    localparam int W    = count * d,
    localparam int RW   = (d > 1) ? count * (d - 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] rnd,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

    occ_e         occ_q, occ_d;
    logic [W-1:0] m_q, m_d, s_q, s_d, cap;
    logic         ov_q, ov_d, ir_q, ir_d;
    logic         acc, pop;

`ifdef MSK_PIPE_REFRESH_EN
    assign acc       = in_valid & ir_q & rnd_valid;
    assign rnd_ready = acc;
    generate
        if (d > 1) begin : g_rf
            for (genvar i = 0; i < count; i++) begin : g_lane
                msk_share_refresh_lane #(.d(d)) u_lane (
                    .sh_i (in_data[i*d +: d]),
                    .r_i  (rnd[i*(d-1) +: (d-1)]),
                    .sh_o (cap[i*d +: d])
                );
            end
        end else begin : g_id
            logic unused_rnd;
            assign unused_rnd = ^rnd;
            assign cap        = in_data;
        end
    endgenerate
`else
    logic unused_rnd;
    assign unused_rnd = ^{rnd, rnd_valid};
    assign acc        = in_valid & ir_q;
    assign rnd_ready  = 1'b0;
    assign cap        = in_data;
`endif

    assign pop = ov_q & out_ready;

    always_comb begin
        occ_d = occ_q;
        m_d   = m_q;
        s_d   = s_q;
        case (occ_q)
            EMPTY: if (acc) begin
                m_d   = cap;
                occ_d = ONE;
            end
            ONE: begin
                if (acc && !pop) begin
                    s_d   = cap;
                    occ_d = FULL;
                end else if (acc && pop) begin
                    m_d = cap;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            FULL: if (pop) begin
                m_d   = s_q;
                occ_d = ONE;
            end
            default: occ_d = EMPTY;
        endcase
        // Handshake outputs are flopped from the next occupancy: no comb path from inputs.
        ov_d = (occ_d != EMPTY);
        ir_d = (occ_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= EMPTY;
            ov_q  <= 1'b0;
            ir_q  <= 1'b1;
        end else begin
            occ_q <= occ_d;
            ov_q  <= ov_d;
            ir_q  <= ir_d;
        end
    end

    always_ff @(posedge clk) begin
        m_q <= m_d;
        s_q <= s_d;
    end

    assign out_data  = m_q;
    assign out_valid = ov_q;
    assign in_ready  = ir_q;
endmodule

// File: tb/tb_msk_share_skid_pipe.sv
// Directed table plus random scoreboard for msk_share_skid_pipe at d=2, count=1.
module tb_msk_share_skid_pipe;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
    logic [1:0] in_data, out_data;
    logic [0:0] rnd;

    always #5 clk = ~clk;

    msk_share_skid_pipe #(.d(2), .count(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [1:0] din;
        logic       ordy;
        logic       ov;
        logic       ir;
        logic [1:0] dout;
        logic       chkd;
    } vec_t;

    vec_t tbl [24];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [1:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // With refresh the shares change; only the unmasked value is stable.
    function automatic logic [1:0] dval(input logic [1:0] v);
`ifdef MSK_PIPE_REFRESH_EN
        return {1'b0, ^v};
`else
        return v;
`endif
    endfunction

    initial begin
        //           rst   iv    din    ordy  ov    ir    dout   chkd
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            logic [1:0] kv;
            kv = 2'(k % 4);
            tbl[3+k] = '{1'b0, 1'b1, kv, 1'b1, 1'b1, 1'b1, kv, 1'b1};
        end
        tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rnd = '0; rnd_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].din;
            out_ready = tbl[i].ordy;
            rnd       = 1'($urandom);
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            if (tbl[i].chkd)
                chk($sformatf("v%0d out_data", i), 32'(dval(out_data)), 32'(dval(tbl[i].dout)));
`ifndef MSK_PIPE_REFRESH_EN
            chk($sformatf("v%0d rnd_ready", i), 32'(rnd_ready), 32'd0);
`endif
        end

        // Random handshake traffic against a reference FIFO of depth 2.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        for (int c = 0; c < 4000; c++) begin
            logic acc, pop;
            chk("rand out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rand in_ready", 32'(in_ready), 32'(q.size() < 2));
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rnd_valid = ($urandom_range(0, 3) != 0);
            in_data   = 2'($urandom);
            rnd       = 1'($urandom);
            acc = in_valid && (q.size() < 2);
`ifdef MSK_PIPE_REFRESH_EN
            acc = acc && rnd_valid;
`endif
            pop = (q.size() != 0) && out_ready;
            #1;
            chk("rand rnd_ready", 32'(rnd_ready),
`ifdef MSK_PIPE_REFRESH_EN
                32'(acc)
`else
                32'd0
`endif
            );
            if (pop) chk("rand pop data", 32'(dval(out_data)), 32'(dval(q.pop_front())));
            if (acc) q.push_back(in_data);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
